controle_multiciclo: RTL

Multi-cycle control unit for the 4-bit-opcode processor datapath. Sequences each instruction through fetch, decode, execute and write-back states, handshakes with instruction memory, and drives the PC, IR, register-file and ULA select/enable lines. Instruction decode comes from CODOP, taken from the IR. The block also keeps a retired-fetch counter and a halt flag for the bench.

---
 rtl/controle_pkg.sv | 57 +++++
 rtl/controle_multiciclo_if.sv | 30 +++
 rtl/contador_instr.sv | 30 +++
 rtl/controle_multiciclo.sv | 102 ++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared types and encodings for the multi-cycle control unit: FSM states, opcodes
// and the select/operation codes driven towards the datapath.
package controle_pkg;

    typedef enum logic [2:0] {
        BUSCA,
        DECOD,
        EXEC,
        ESCRITA,
        DESVIO,
        SALTO,
        HALT
    } estado_t;

    localparam logic [3:0] OP_SALTO  = 4'b1011;
    localparam logic [3:0] OP_DESVIO = 4'b1100;
    localparam logic [3:0] OP_PARA   = 4'b1111;

    localparam logic [1:0] CP_ULA   = 2'b00;
    localparam logic [1:0] CP_ALVO  = 2'b01;
    localparam logic [1:0] CP_SALTO = 2'b10;

    localparam logic [1:0] ULA_SOMA = 2'b00;
    localparam logic [1:0] ULA_SUB  = 2'b01;
    localparam logic [1:0] ULA_FUNC = 2'b10;

    localparam logic       A_CP   = 1'b0;
    localparam logic       A_REG  = 1'b1;
    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_UM   = 2'b01;
    localparam logic [1:0] B_IMED = 2'b10;

    typedef struct packed {
        logic       lemem;
        logic       escir;
        logic       esccp;
        logic       esccondcp;
        logic [1:0] fontecp;
        logic       ulafontea;
        logic [1:0] ulafonteb;
        logic [1:0] ulaop;
        logic       escreg;
        logic       parado;
    } controle_t;

    function automatic estado_t decodifica(input logic [3:0] codop);
        estado_t prox;
        case (codop)
            OP_SALTO:  prox = SALTO;
            OP_DESVIO: prox = DESVIO;
            OP_PARA:   prox = HALT;
            default:   prox = EXEC;
        endcase
        return prox;
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control bus between the control unit (master) and the datapath/instruction memory (slave).
interface controle_multiciclo_if #(
    parameter int unsigned LARGURA_CONT = 16
);
    logic [3:0]              CODOP;
    logic                    MEMPRONTA;
    logic                    LEMEM;
    logic                    ESCIR;
    logic                    ESCCP;
    logic                    ESCCONDCP;
    logic [1:0]              FONTECP;
    logic                    ULAFONTEA;
    logic [1:0]              ULAFONTEB;
    logic [1:0]              ULAOP;
    logic                    ESCREG;
    logic                    PARADO;
    logic [LARGURA_CONT-1:0] NINSTR;

    modport master (
        input  CODOP, MEMPRONTA,
        output LEMEM, ESCIR, ESCCP, ESCCONDCP, FONTECP, ULAFONTEA, ULAFONTEB, ULAOP,
               ESCREG, PARADO, NINSTR
    );

    modport slave (
        output CODOP, MEMPRONTA,
        input  LEMEM, ESCIR, ESCCP, ESCCONDCP, FONTECP, ULAFONTEA, ULAFONTEB, ULAOP,
               ESCREG, PARADO, NINSTR
    );
endinterface

// File: rtl/contador_instr.sv
// Wrapping enable counter that tallies completed instruction fetches.
module contador_instr #(
    parameter int unsigned LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    output logic [LARGURA-1:0] cont_o
);
    localparam logic [LARGURA-1:0] Um = LARGURA'(1);

    logic [LARGURA-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (en_i) begin
            cont_d = cont_q + Um;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign cont_o = cont_q;
endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit: fetch/decode/execute/write-back sequencing for the
// 4-bit-opcode datapath, plus a fetch counter and halt flag.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int unsigned LARGURA_CONT = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    controle_multiciclo_if.master  bus
);
    estado_t   estado_q, estado_d;
    controle_t ctl;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado_q <= BUSCA;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            BUSCA:   if (bus.MEMPRONTA) estado_d = DECOD;
            DECOD:   estado_d = decodifica(bus.CODOP);
            EXEC:    estado_d = ESCRITA;
            ESCRITA: estado_d = BUSCA;
            DESVIO:  estado_d = BUSCA;
            SALTO:   estado_d = BUSCA;
            HALT:    estado_d = HALT;
            default: estado_d = BUSCA;
        endcase
    end

    always_comb begin
        ctl = '0;
        case (estado_q)
            BUSCA: begin
                ctl.lemem = 1'b1;
                // PC <- PC + 1 only in the cycle memory delivers the word
                if (bus.MEMPRONTA) begin
                    ctl.escir     = 1'b1;
                    ctl.esccp     = 1'b1;
                    ctl.fontecp   = CP_ULA;
                    ctl.ulafontea = A_CP;
                    ctl.ulafonteb = B_UM;
                    ctl.ulaop     = ULA_SOMA;
                end
            end
            DECOD: begin
                ctl.ulafontea = A_CP;
                ctl.ulafonteb = B_IMED;
                ctl.ulaop     = ULA_SOMA;
            end
            EXEC: begin
                ctl.ulafontea = A_REG;
                ctl.ulafonteb = B_REG;
                ctl.ulaop     = ULA_FUNC;
            end
            ESCRITA: ctl.escreg = 1'b1;
            DESVIO: begin
                ctl.ulafontea = A_REG;
                ctl.ulafonteb = B_REG;
                ctl.ulaop     = ULA_SUB;
                ctl.esccondcp = 1'b1;
                ctl.fontecp   = CP_ALVO;
            end
            SALTO: begin
                ctl.esccp   = 1'b1;
                ctl.fontecp = CP_SALTO;
            end
            HALT:    ctl.parado = 1'b1;
            default: ctl = '0;
        endcase
        // Reset silences every control immediately, so an aborted instruction writes nothing
        if (RST) begin
            ctl = '0;
        end
    end

    assign bus.LEMEM     = ctl.lemem;
    assign bus.ESCIR     = ctl.escir;
    assign bus.ESCCP     = ctl.esccp;
    assign bus.ESCCONDCP = ctl.esccondcp;
    assign bus.FONTECP   = ctl.fontecp;
    assign bus.ULAFONTEA = ctl.ulafontea;
    assign bus.ULAFONTEB = ctl.ulafonteb;
    assign bus.ULAOP     = ctl.ulaop;
    assign bus.ESCREG    = ctl.escreg;
    assign bus.PARADO    = ctl.parado;

    contador_instr #(
        .LARGURA (LARGURA_CONT)
    ) u_contador (
        .clk    (CLK),
        .rst    (RST),
        .en_i   (ctl.escir),
        .cont_o (bus.NINSTR)
    );
endmodule
